// File: rtl/video_timing.sv
`timescale 1ns/1ps
// video_timing -- raster timing generator with double-buffered, run-time
// reloadable timing.
//
// A pixel/line counter pair (x, y) walks the frame one step per aclk cycle
// in which pix_ce is high. Blanking and sync flags are decoded combinationally
// from the counters against the *active* timing set. A new timing set is
// offered over a valid/ready handshake. If it is well ordered on both axes,
// it is parked in a shadow set. It then becomes active exactly at the next
// frame wrap, so a frame never mixes two timings. A badly ordered set is
// dropped and cfg_err pulses for one cycle.
//
// Optional feature: define VIDEO_TIMING_LINE_IRQ_EN to build a sticky line
// interrupt. The interrupt sets when (x == 0, y == irq_line) and clears on
// irq_ack; a set in the same cycle as an ack wins. Without the macro, irq is
// tied low and irq_line/irq_ack are ignored.
//
// Ports
//   aclk, aresetn        clock; asynchronous active-low reset
//   pix_ce               pixel clock enable
//   cfg_valid/cfg_ready  timing-set handshake (ready = shadow slot free)
//   cfg_h_*, cfg_v_*     offered timing: active, fp_end, sync_end, total
//   cfg_hpol, cfg_vpol   offered sync polarity (1 = active-high)
//   cfg_err              one-cycle pulse when an offered set is rejected
//   x, y                 current pixel / line
//   hblank, vblank, de   blanking flags and display enable
//   hsync, vsync         sync outputs with polarity applied
//   sol, sof             start-of-line / start-of-frame strobes
//   irq_line, irq_ack    line-compare value and interrupt clear
//   irq                  sticky line interrupt
module video_timing #(
  parameter int CW         = 12,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP_END   = 656,
  parameter int H_SYNC_END = 752,
  parameter int H_TOTAL    = 800,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP_END   = 490,
  parameter int V_SYNC_END = 492,
  parameter int V_TOTAL    = 525,
  parameter bit HPOL       = 1'b0,
  parameter bit VPOL       = 1'b0
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          pix_ce,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_h_active,
  input  logic [CW-1:0] cfg_h_fp_end,
  input  logic [CW-1:0] cfg_h_sync_end,
  input  logic [CW-1:0] cfg_h_total,
  input  logic [CW-1:0] cfg_v_active,
  input  logic [CW-1:0] cfg_v_fp_end,
  input  logic [CW-1:0] cfg_v_sync_end,
  input  logic [CW-1:0] cfg_v_total,
  input  logic          cfg_hpol,
  input  logic          cfg_vpol,
  output logic          cfg_err,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          hblank,
  output logic          vblank,
  output logic          de,
  output logic          hsync,
  output logic          vsync,
  output logic          sol,
  output logic          sof,
  input  logic [CW-1:0] irq_line,
  input  logic          irq_ack,
  output logic          irq
);

  // One axis worth of timing. Both axes share the same shape, so index 0 is
  // horizontal and index 1 is vertical throughout this file.
  typedef struct packed {
    logic [CW-1:0] act;
    logic [CW-1:0] fp_end;
    logic [CW-1:0] sync_end;
    logic [CW-1:0] total;
    logic          pol;
  } axis_t;

  localparam axis_t DEF_H = '{act: CW'(H_ACTIVE), fp_end: CW'(H_FP_END),
                              sync_end: CW'(H_SYNC_END), total: CW'(H_TOTAL),
                              pol: HPOL};
  localparam axis_t DEF_V = '{act: CW'(V_ACTIVE), fp_end: CW'(V_FP_END),
                              sync_end: CW'(V_SYNC_END), total: CW'(V_TOTAL),
                              pol: VPOL};
  localparam axis_t [1:0] DEF_SET = {DEF_V, DEF_H};

  axis_t [1:0]         act_reg, act_next;
  axis_t [1:0]         shd_reg, shd_next;
  axis_t [1:0]         cfg_set;
  logic [1:0][CW-1:0]  pos;
  logic [CW-1:0]       x_reg, x_next;
  logic [CW-1:0]       y_reg, y_next;
  logic                pending_reg, pending_next;
  logic                cfg_err_reg, cfg_err_next;
  logic [1:0]          axis_ok;
  logic [1:0]          blank;
  logic [1:0]          sync_raw;
  logic [1:0]          sync_out;
  logic                x_last, y_last, xfer, cfg_ok;

  assign cfg_set[0] = '{act: cfg_h_active, fp_end: cfg_h_fp_end,
                        sync_end: cfg_h_sync_end, total: cfg_h_total,
                        pol: cfg_hpol};
  assign cfg_set[1] = '{act: cfg_v_active, fp_end: cfg_v_fp_end,
                        sync_end: cfg_v_sync_end, total: cfg_v_total,
                        pol: cfg_vpol};
  assign pos = {y_reg, x_reg};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      // Offered set must satisfy 0 < active <= fp_end <= sync_end < total.
      assign axis_ok[gi] = (cfg_set[gi].act != '0) &&
                           (cfg_set[gi].act <= cfg_set[gi].fp_end) &&
                           (cfg_set[gi].fp_end <= cfg_set[gi].sync_end) &&
                           (cfg_set[gi].sync_end < cfg_set[gi].total);
      assign blank[gi]    = (pos[gi] >= act_reg[gi].act);
      assign sync_raw[gi] = (pos[gi] >= act_reg[gi].fp_end) &&
                            (pos[gi] < act_reg[gi].sync_end);
      // XNOR: with pol = 0 the output is driven low while sync is active.
      assign sync_out[gi] = ~(sync_raw[gi] ^ act_reg[gi].pol);
    end
  endgenerate

  assign cfg_ok = &axis_ok;
  assign xfer   = cfg_valid & ~pending_reg;
  assign x_last = (x_reg == act_reg[0].total - CW'(1));
  assign y_last = (y_reg == act_reg[1].total - CW'(1));

  always_comb begin
    x_next       = x_reg;
    y_next       = y_reg;
    act_next     = act_reg;
    shd_next     = shd_reg;
    pending_next = pending_reg;
    cfg_err_next = 1'b0;

    // The handshake runs regardless of pix_ce. A transfer can only happen with
    // pending low, so it never collides with the shadow-to-active copy below.
    if (xfer) begin
      if (cfg_ok) begin
        shd_next     = cfg_set;
        pending_next = 1'b1;
      end else begin
        cfg_err_next = 1'b1;
      end
    end

    if (pix_ce) begin
      if (x_last) begin
        x_next = '0;
        if (y_last) begin
          y_next = '0;
          // The swap uses the pending flag registered before this edge.
          // A set accepted in the wrap cycle therefore waits one full frame.
          if (pending_reg) begin
            act_next     = shd_reg;
            pending_next = 1'b0;
          end
        end else begin
          y_next = y_reg + CW'(1);
        end
      end else begin
        x_next = x_reg + CW'(1);
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      x_reg       <= '0;
      y_reg       <= '0;
      act_reg     <= DEF_SET;
      shd_reg     <= DEF_SET;
      pending_reg <= 1'b0;
      cfg_err_reg <= 1'b0;
    end else begin
      x_reg       <= x_next;
      y_reg       <= y_next;
      act_reg     <= act_next;
      shd_reg     <= shd_next;
      pending_reg <= pending_next;
      cfg_err_reg <= cfg_err_next;
    end
  end

  assign x         = x_reg;
  assign y         = y_reg;
  assign hblank    = blank[0];
  assign vblank    = blank[1];
  assign de        = ~blank[0] & ~blank[1];
  assign hsync     = sync_out[0];
  assign vsync     = sync_out[1];
  assign sol       = pix_ce & (x_reg == '0);
  assign sof       = sol & (y_reg == '0);
  assign cfg_ready = ~pending_reg;
  assign cfg_err   = cfg_err_reg;

`ifdef VIDEO_TIMING_LINE_IRQ_EN
  logic irq_reg;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      irq_reg <= 1'b0;
    end else if (sol && (y_reg == irq_line)) begin
      irq_reg <= 1'b1;
    end else if (irq_ack) begin
      irq_reg <= 1'b0;
    end
  end

  assign irq = irq_reg;
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = &{1'b0, irq_line, irq_ack};
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_video_timing.sv
`timescale 1ns/1ps
// Bench for video_timing. Two instances share one stimulus stream:
// instance 0 uses the 640x480 defaults, and instance 1 uses a small 24x10
// default frame so that frame wraps and timing reloads happen often.
// A reference model tracks each instance as a linear pixel index inside
// the frame. Each cycle, the driver pushes the predicted outputs into a
// per-instance queue. A negedge monitor pops the queues and compares.
module tb_video_timing;
  localparam int CW = 12;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic hblank, vblank, de, hsync, vsync, sol, sof, cfg_ready, cfg_err, irq;
  } exp_t;

  typedef struct {
    int ha, hf, hs, ht, va, vf, vs, vt;
    bit hp, vp;
  } tm_t;

  logic          aclk      = 1'b0;
  logic          aresetn   = 1'b1;
  logic          pix_ce    = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          irq_ack   = 1'b0;
  logic [CW-1:0] irq_line  = '0;
  tm_t           stim;

  logic [CW-1:0] c_ha, c_hf, c_hs, c_ht, c_va, c_vf, c_vs, c_vt;
  logic          c_hp, c_vp;
  assign c_ha = CW'(stim.ha);
  assign c_hf = CW'(stim.hf);
  assign c_hs = CW'(stim.hs);
  assign c_ht = CW'(stim.ht);
  assign c_va = CW'(stim.va);
  assign c_vf = CW'(stim.vf);
  assign c_vs = CW'(stim.vs);
  assign c_vt = CW'(stim.vt);
  assign c_hp = stim.hp;
  assign c_vp = stim.vp;

  logic [CW-1:0] x_o [2];
  logic [CW-1:0] y_o [2];
  logic hb_o [2], vb_o [2], de_o [2], hs_o [2], vs_o [2];
  logic sol_o [2], sof_o [2], rdy_o [2], err_o [2], irq_o [2];
  exp_t got [2];

  always #5 aclk = ~aclk;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      video_timing #(
        .CW(CW),
        .H_ACTIVE(gi == 0 ? 640 : 16), .H_FP_END(gi == 0 ? 656 : 18),
        .H_SYNC_END(gi == 0 ? 752 : 20), .H_TOTAL(gi == 0 ? 800 : 24),
        .V_ACTIVE(gi == 0 ? 480 : 6), .V_FP_END(gi == 0 ? 490 : 7),
        .V_SYNC_END(gi == 0 ? 492 : 8), .V_TOTAL(gi == 0 ? 525 : 10),
        .HPOL(gi == 0 ? 1'b0 : 1'b1), .VPOL(1'b0)
      ) u_dut (
        .aclk(aclk), .aresetn(aresetn), .pix_ce(pix_ce),
        .cfg_valid(cfg_valid), .cfg_ready(rdy_o[gi]),
        .cfg_h_active(c_ha), .cfg_h_fp_end(c_hf),
        .cfg_h_sync_end(c_hs), .cfg_h_total(c_ht),
        .cfg_v_active(c_va), .cfg_v_fp_end(c_vf),
        .cfg_v_sync_end(c_vs), .cfg_v_total(c_vt),
        .cfg_hpol(c_hp), .cfg_vpol(c_vp), .cfg_err(err_o[gi]),
        .x(x_o[gi]), .y(y_o[gi]), .hblank(hb_o[gi]), .vblank(vb_o[gi]),
        .de(de_o[gi]), .hsync(hs_o[gi]), .vsync(vs_o[gi]),
        .sol(sol_o[gi]), .sof(sof_o[gi]),
        .irq_line(irq_line), .irq_ack(irq_ack), .irq(irq_o[gi])
      );
      assign got[gi] = {x_o[gi], y_o[gi], hb_o[gi], vb_o[gi], de_o[gi],
                        hs_o[gi], vs_o[gi], sol_o[gi], sof_o[gi],
                        rdy_o[gi], err_o[gi], irq_o[gi]};
    end
  endgenerate

  // Reference model state, one slot per instance.
  tm_t  m_def [2];
  tm_t  m_act [2];
  tm_t  m_shd [2];
  int   m_n   [2];
  bit   m_pend[2];
  bit   m_err [2];
  bit   m_irq [2];
  exp_t q0[$];
  exp_t q1[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  function automatic bit set_ok(tm_t s);
    return s.ha > 0 && s.ha <= s.hf && s.hf <= s.hs && s.hs < s.ht &&
           s.va > 0 && s.va <= s.vf && s.vf <= s.vs && s.vs < s.vt;
  endfunction

  function automatic int mx(int i);
    return m_n[i] % m_act[i].ht;
  endfunction

  function automatic int my(int i);
    return m_n[i] / m_act[i].ht;
  endfunction

  function automatic void mreset(int i);
    m_n[i]    = 0;
    m_act[i]  = m_def[i];
    m_shd[i]  = m_def[i];
    m_pend[i] = 1'b0;
    m_err[i]  = 1'b0;
    m_irq[i]  = 1'b0;
  endfunction

  function automatic exp_t predict(int i);
    exp_t e;
    tm_t  t;
    int   px, ln;
    bit   hr, vr, sl;
    t  = m_act[i];
    px = mx(i);
    ln = my(i);
    hr = (px >= t.hf) && (px < t.hs);
    vr = (ln >= t.vf) && (ln < t.vs);
    sl = pix_ce && (px == 0);
    e.x         = CW'(px);
    e.y         = CW'(ln);
    e.hblank    = (px >= t.ha);
    e.vblank    = (ln >= t.va);
    e.de        = (px < t.ha) && (ln < t.va);
    e.hsync     = hr ? t.hp : !t.hp;
    e.vsync     = vr ? t.vp : !t.vp;
    e.sol       = sl;
    e.sof       = sl && (ln == 0);
    e.cfg_ready = !m_pend[i];
    e.cfg_err   = m_err[i];
    e.irq       = m_irq[i];
    return e;
  endfunction

  // Advance one instance's model across a clock edge with current inputs.
  function automatic void mstep(int i);
    bit accept_ok;
    bit offered;
    int px, ln;
    tm_t t;
    t         = m_act[i];
    px        = mx(i);
    ln        = my(i);
    offered   = cfg_valid && !m_pend[i];
    accept_ok = set_ok(stim);
`ifdef VIDEO_TIMING_LINE_IRQ_EN
    if (pix_ce && px == 0 && ln == int'(irq_line)) m_irq[i] = 1'b1;
    else if (irq_ack) m_irq[i] = 1'b0;
`endif
    m_err[i] = offered && !accept_ok;
    if (pix_ce) begin
      m_n[i] = m_n[i] + 1;
      if (m_n[i] == t.ht * t.vt) begin
        m_n[i] = 0;
        if (m_pend[i]) begin
          m_act[i]  = m_shd[i];
          m_pend[i] = 1'b0;
        end
      end
    end
    if (offered && accept_ok) begin
      m_shd[i]  = stim;
      m_pend[i] = 1'b1;
    end
  endfunction

  function automatic tm_t rand_set(bit bad);
    tm_t s;
    s.ha = int'($urandom_range(1, 6));
    s.hf = s.ha + int'($urandom_range(0, 2));
    s.hs = s.hf + int'($urandom_range(0, 3));
    s.ht = s.hs + int'($urandom_range(1, 3));
    s.va = int'($urandom_range(1, 4));
    s.vf = s.va + int'($urandom_range(0, 2));
    s.vs = s.vf + int'($urandom_range(0, 2));
    s.vt = s.vs + int'($urandom_range(1, 3));
    s.hp = 1'($urandom_range(0, 1));
    s.vp = 1'($urandom_range(0, 1));
    if (bad) begin
      case ($urandom_range(0, 3))
        0:       s.ha = 0;
        1:       s.hf = s.hs + 1;
        2:       s.vt = s.vs;
        default: s.va = s.vf + 1;
      endcase
    end
    return s;
  endfunction

  // Called just after a rising edge with the inputs for this cycle driven.
  task automatic tick();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (!aresetn) mreset(i);
      e = predict(i);
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    @(posedge aclk);
    for (int i = 0; i < 2; i++) begin
      if (aresetn) mstep(i);
      else         mreset(i);
    end
    #1;
    cyc++;
  endtask

  task automatic check(int i, exp_t e);
    vectors++;
    if (got[i] !== e) begin
      miscompares++;
      $display("FAIL dut%0d cycle %0d: got x=%0d y=%0d flags=%b, required x=%0d y=%0d flags=%b (hb vb de hs vs sol sof rdy err irq)",
               i, cyc, got[i].x, got[i].y, got[i][9:0], e.x, e.y, e[9:0]);
    end
  endtask

  always @(negedge aclk) begin
    if (q0.size() > 0) check(0, q0.pop_front());
    if (q1.size() > 0) check(1, q1.pop_front());
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    tm_t good;
    int  occ;
    bit  at_set;
    m_def[0] = '{640, 656, 752, 800, 480, 490, 492, 525, 1'b0, 1'b0};
    m_def[1] = '{16, 18, 20, 24, 6, 7, 8, 10, 1'b1, 1'b0};
    mreset(0);
    mreset(1);
    stim = m_def[0];
    @(posedge aclk);
    #1;

    // Reset state.
    aresetn = 1'b0;
    repeat (3) tick();
    aresetn = 1'b1;

    // Default timing, free running: two full lines of instance 0.
    pix_ce = 1'b1;
    repeat (1700) tick();

    // Mid-frame 8x5 set; held pending until each instance's frame ends.
    good = '{4, 5, 6, 8, 2, 3, 4, 5, 1'b0, 1'b0};
    stim = good;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    repeat (300) tick();

    // Rejected sets: h_active = 0, then fp_end beyond sync_end.
    stim = good;
    stim.ha = 0;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    repeat (3) tick();
    stim = good;
    stim.hf = 7;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    repeat (3) tick();

    // pix_ce toggling.
    for (int k = 0; k < 100; k++) begin
      pix_ce = 1'(k % 2);
      tick();
    end
    pix_ce = 1'b1;

    // Line interrupt on line 2, acknowledging at the set cycle on every other
    // occurrence and at random times otherwise.
    irq_line = CW'(2);
    occ = 0;
    for (int k = 0; k < 200; k++) begin
      at_set = (mx(1) == 0) && (my(1) == 2);
      if (at_set) begin
        occ++;
        irq_ack = (occ % 2 == 0);
      end else begin
        irq_ack = ($urandom_range(0, 5) == 0);
      end
      tick();
    end
    irq_ack = 1'b0;

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      pix_ce    = ($urandom_range(0, 3) != 0);
      cfg_valid = ($urandom_range(0, 15) == 0);
      if (cfg_valid) stim = rand_set($urandom_range(0, 2) == 0);
      irq_ack = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 63) == 0) irq_line = CW'($urandom_range(0, 5));
      tick();
    end
    cfg_valid = 1'b0;
    irq_ack   = 1'b0;

    // Reset mid-frame with a set pending.
    pix_ce = 1'b1;
    for (int k = 0; k < 500 && m_pend[1]; k++) tick();
    stim = good;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    repeat (3) tick();
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    repeat (60) tick();

    @(negedge aclk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/video_timing.md
VIDEO_TIMING -- requirements
Module: video_timing

Interface
REQ-001 Parameter CW, default 12: width of every counter, timing field and coordinate port.
REQ-002 Parameters H_ACTIVE/H_FP_END/H_SYNC_END/H_TOTAL, defaults 640/656/752/800: reset horizontal timing (pixel counts, exclusive end points).
REQ-003 Parameters V_ACTIVE/V_FP_END/V_SYNC_END/V_TOTAL, defaults 480/490/492/525: reset vertical timing (line counts).
REQ-004 Parameters HPOL/VPOL, default 0/0: reset sync polarity (0 = active-low pulse, 1 = active-high pulse).
REQ-005 Port list, one per line: name, direction, width, meaning; clock and reset first.
- aclk  in  1  clock.
- aresetn  in  1  reset; asynchronous, active-low.
- pix_ce  in  1  pixel clock enable; counters advance only when high.
- cfg_valid  in  1  new timing set offered.
- cfg_ready  out  1  shadow register free.
- cfg_h_active, cfg_h_fp_end, cfg_h_sync_end, cfg_h_total  in  CW each  horizontal timing.
- cfg_v_active, cfg_v_fp_end, cfg_v_sync_end, cfg_v_total  in  CW each  vertical timing.
- cfg_hpol, cfg_vpol  in  1 each  sync polarity.
- cfg_err  out  1  one-cycle pulse: offered set rejected.
- x, y  out  CW each  current pixel/line coordinate.
- hblank, vblank, de  out  1 each  blanking flags; de = ~hblank & ~vblank.
- hsync, vsync  out  1 each  sync outputs, polarity applied.
- sol, sof  out  1 each  start-of-line / start-of-frame strobes.
- irq_line  in  CW  line-compare value (IRQ build only).
- irq_ack  in  1  clears irq (IRQ build only).
- irq  out  1  sticky line interrupt.

Function
REQ-006 x SHALL count up from 0 on each aclk with pix_ce=1; at x = h_total-1 it SHALL wrap to 0 and y SHALL increment; at y = v_total-1 with that wrap, y SHALL wrap to 0.
REQ-007 With pix_ce=0 the counters and all shadow/active timing registers SHALL hold; the config handshake still operates.
REQ-008 hblank = (x >= h_active); vblank = (y >= v_active); both decoded combinationally from the x/y registers, zero latency.
REQ-009 Raw hsync active while h_fp_end <= x < h_sync_end, and raw vsync active while v_fp_end <= y < v_sync_end; each output = raw XNOR pol (pol=0 drives 0 while active).
REQ-010 sol = pix_ce & (x == 0); sof = sol & (y == 0).
REQ-011 cfg_ready = ~pending; a transfer occurs when cfg_valid & cfg_ready are high in the same cycle.
REQ-012 An offered set is valid only if 0 < active <= fp_end <= sync_end < total on both axes.
REQ-013 Valid transfer: the set SHALL be latched into the shadow registers and pending set.
REQ-014 Invalid transfer: the set SHALL be discarded, cfg_err pulsed for one cycle, and pending left at 0.
REQ-015 When pending=1 and the counters wrap from (h_total-1, v_total-1) to (0,0), the shadow set SHALL become the active set in that same edge and pending SHALL clear; cfg_ready rises the following cycle.
REQ-016 A transfer in the wrap cycle (pending=0) SHALL NOT apply at that wrap; it applies at the next frame wrap.
REQ-017 Timing SHALL never change mid-frame; x and y always stay below the active h_total and v_total.

Reset
REQ-018 On aresetn=0, asynchronously:
- x = y = 0.
- Active set = parameter defaults; shadow set = parameter defaults.
- pending = 0, cfg_err = 0, irq = 0.
REQ-019 Derived outputs right after reset: cfg_ready=1, hblank=vblank=0, de=1, hsync=vsync inactive level.

Configuration
REQ-020 Macro VIDEO_TIMING_LINE_IRQ_EN.
- Defined: irq SHALL set when pix_ce & (x == 0) & (y == irq_line), and clear on irq_ack; set wins over a simultaneous ack.
- Undefined: irq is tied to 0, irq_line/irq_ack are ignored, and no IRQ logic is synthesised.

Verification
REQ-021 Bench SHALL cover the following directed scenarios:
- Default timing, pix_ce=1 -> hsync low for x=656..751; hblank high for x=640..799; x wraps 799->0 with y+1; sof once per 420000 cycles.
- Accept cfg h=4/5/6/8, v=2/3/4/5 mid-frame -> cfg_ready=0 until default frame ends; then an 8x5 frame (40 pixels) with hsync at x=5 and vsync at y=3.
- Offer h_active=0, or h_fp_end > h_sync_end -> cfg_err pulse for 1 cycle; cfg_ready stays 1; timing unchanged.
- pix_ce toggling 1/0 -> x advances once per two cycles; sol is high only in cycles with pix_ce=1.
- IRQ build, irq_line=2, 8x5 frame -> irq rises at (0,2); irq_ack pulse clears it; with ack at the set cycle, irq stays 1.
- Assert aresetn mid-frame with pending=1 -> x=y=0, default timing restored, cfg_ready=1 the next cycle.
